// File: rtl/csi_capture_pkg.sv
// Shared types and constants for the CSI capture controller.
// State encodings are exported so host-visible state_out values have one
// definition. TSTAMP only appears when CSI_CAPTURE_TIMESTAMP_EN is defined.
package csi_capture_pkg;

   localparam logic [15:0] CSI_HDR_MAGIC = 16'hC51F;

   localparam logic [3:0] STATE_IDLE       = 4'd0;
   localparam logic [3:0] STATE_WAIT_POWER = 4'd1;
   localparam logic [3:0] STATE_SYNC_SHORT = 4'd2;
   localparam logic [3:0] STATE_SYNC_LONG  = 4'd3;
   localparam logic [3:0] STATE_HEADER     = 4'd4;
   localparam logic [3:0] STATE_TSTAMP     = 4'd5;
   localparam logic [3:0] STATE_PAYLOAD    = 4'd6;
   localparam logic [3:0] STATE_DRAIN      = 4'd7;
   localparam logic [3:0] STATE_HOLDOFF    = 4'd8;

   typedef enum logic [3:0] {
      ST_IDLE       = STATE_IDLE,
      ST_WAIT_POWER = STATE_WAIT_POWER,
      ST_SYNC_SHORT = STATE_SYNC_SHORT,
      ST_SYNC_LONG  = STATE_SYNC_LONG,
      ST_HEADER     = STATE_HEADER,
      ST_TSTAMP     = STATE_TSTAMP,
      ST_PAYLOAD    = STATE_PAYLOAD,
      ST_DRAIN      = STATE_DRAIN,
      ST_HOLDOFF    = STATE_HOLDOFF
   } capture_state_t;

endpackage

// File: rtl/csi_axis_skid.sv
// One-entry registered AXI-Stream stage. Accepts a new beat whenever the
// register is empty or is being drained in the same cycle, so it sustains
// one beat per clock. Output data/last hold while valid is stalled.
module csi_axis_skid #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  out_ready
);

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;

   assign in_ready  = !vld_p1 || out_ready;
   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_last  = last_p1;

   // Output register: load on accept, empty when the consumer takes the beat
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (in_valid && in_ready) begin
         vld_p1  <= 1'b1;
         data_p1 <= in_data;
         last_p1 <= in_last;
      end else if (out_ready) begin
         vld_p1  <= 1'b0;
      end
   end

endmodule

// File: rtl/csi_capture_ctrl.sv
// Packet-acquisition sequencer and CSI framer. Drives the short/long sync
// stages, applies search timeouts and a post-frame hold-off, and wraps each
// equalizer CSI frame behind a {magic, frame_count} header word.
// Optional macro CSI_CAPTURE_TIMESTAMP_EN adds a second header word carrying
// the cycle count latched when the long-preamble search begins.
module csi_capture_ctrl
   import csi_capture_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int SHORT_TIMEOUT   = 640,
   parameter int LTS_WINDOW      = 320,
   parameter int HOLDOFF_CYCLES  = 64,
   parameter int NUM_SUBCARRIERS = 64
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   input  logic                  sample_valid_in,
   input  logic                  power_trigger_in,
   input  logic                  short_detected_in,
   output logic                  sync_short_rst_out,
   output logic                  sync_long_rst_out,
   output logic                  short_sample_en_out,
   output logic                  long_sample_en_out,
   input  logic                  csi_s_axis_tvalid,
   input  logic                  csi_s_axis_tlast,
   input  logic [DATA_WIDTH-1:0] csi_s_axis_tdata,
   output logic                  csi_s_axis_tready,
   output logic                  csi_m_axis_tvalid,
   output logic                  csi_m_axis_tlast,
   output logic [DATA_WIDTH-1:0] csi_m_axis_tdata,
   input  logic                  csi_m_axis_tready,
   output logic [3:0]            state_out,
   output logic [15:0]           frame_count_out,
   output logic [15:0]           abort_count_out,
   output logic [15:0]           error_count_out,
   output logic                  overflow_out
);

   localparam int MAX_AB  = (SHORT_TIMEOUT > LTS_WINDOW) ? SHORT_TIMEOUT : LTS_WINDOW;
   localparam int MAX_CNT = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;
   localparam int BEAT_W  = $clog2(NUM_SUBCARRIERS) + 1;

   capture_state_t        state;
   logic [CNT_W-1:0]      sample_cnt;
   logic [CNT_W-1:0]      hold_cnt;
   logic [BEAT_W-1:0]     beat_cnt;

   logic                  skid_in_valid;
   logic [DATA_WIDTH-1:0] skid_in_data;
   logic                  skid_in_last;
   logic                  skid_in_ready;
   logic                  discard_st;
   logic                  last_beat;
   logic                  beat_acc;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

`ifdef CSI_CAPTURE_TIMESTAMP_EN
   logic [31:0] cycle_cnt;
   logic [31:0] tstamp_q;

   // Free-running cycle counter, sampled as the long-preamble search starts
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cycle_cnt <= '0;
         tstamp_q  <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (state == ST_SYNC_SHORT && short_detected_in)
            tstamp_q <= cycle_cnt;
      end
   end
`endif

   assign state_out           = state;
   assign short_sample_en_out = (state == ST_SYNC_SHORT) && sample_valid_in;
   assign long_sample_en_out  = (state == ST_SYNC_LONG) && sample_valid_in;
   assign discard_st          = (state == ST_IDLE) || (state == ST_WAIT_POWER) ||
                                (state == ST_SYNC_SHORT) || (state == ST_HOLDOFF);
   assign last_beat           = (beat_cnt == BEAT_W'(NUM_SUBCARRIERS - 1));
   assign beat_acc            = (state == ST_PAYLOAD) && csi_s_axis_tvalid && skid_in_ready;

   // Stream steering: header words, payload pass-through, or sink/stall input
   always_comb begin
      skid_in_valid     = 1'b0;
      skid_in_data      = '0;
      skid_in_last      = 1'b0;
      csi_s_axis_tready = 1'b0;
      case (state)
         ST_IDLE, ST_WAIT_POWER, ST_SYNC_SHORT, ST_HOLDOFF, ST_DRAIN:
            csi_s_axis_tready = 1'b1;
         ST_HEADER: begin
            skid_in_valid = 1'b1;
            skid_in_data  = DATA_WIDTH'({CSI_HDR_MAGIC, frame_count_out});
         end
`ifdef CSI_CAPTURE_TIMESTAMP_EN
         ST_TSTAMP: begin
            skid_in_valid = 1'b1;
            skid_in_data  = DATA_WIDTH'(tstamp_q);
         end
`endif
         ST_PAYLOAD: begin
            skid_in_valid     = csi_s_axis_tvalid;
            skid_in_data      = csi_s_axis_tdata;
            skid_in_last      = csi_s_axis_tlast || last_beat;
            csi_s_axis_tready = skid_in_ready;
         end
         default: ;
      endcase
      if (rst_in)
         csi_s_axis_tready = 1'b0;
   end

   // Acquisition FSM with its sample, hold-off, beat and statistics counters
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state              <= ST_IDLE;
         sample_cnt         <= '0;
         hold_cnt           <= '0;
         beat_cnt           <= '0;
         frame_count_out    <= '0;
         abort_count_out    <= '0;
         error_count_out    <= '0;
         overflow_out       <= 1'b0;
         sync_short_rst_out <= 1'b0;
         sync_long_rst_out  <= 1'b0;
      end else begin
         sync_short_rst_out <= 1'b0;
         sync_long_rst_out  <= 1'b0;
         if (discard_st && csi_s_axis_tvalid)
            overflow_out <= 1'b1;
         case (state)
            ST_IDLE:
               if (enable_in)
                  state <= ST_WAIT_POWER;
            ST_WAIT_POWER:
               if (!enable_in) begin
                  state <= ST_IDLE;
               end else if (power_trigger_in) begin
                  state              <= ST_SYNC_SHORT;
                  sync_short_rst_out <= 1'b1;
                  sample_cnt         <= '0;
               end
            ST_SYNC_SHORT:
               if (short_detected_in) begin
                  state             <= ST_SYNC_LONG;
                  sync_long_rst_out <= 1'b1;
                  sample_cnt        <= '0;
               end else if (!power_trigger_in || sample_cnt >= CNT_W'(SHORT_TIMEOUT)) begin
                  state           <= ST_HOLDOFF;
                  abort_count_out <= sat_inc16(abort_count_out);
               end else if (sample_valid_in) begin
                  sample_cnt <= sample_cnt + CNT_W'(1);
               end
            ST_SYNC_LONG:
               if (csi_s_axis_tvalid) begin
                  state <= ST_HEADER;
               end else if (!power_trigger_in || sample_cnt >= CNT_W'(LTS_WINDOW)) begin
                  state           <= ST_HOLDOFF;
                  abort_count_out <= sat_inc16(abort_count_out);
               end else if (sample_valid_in) begin
                  sample_cnt <= sample_cnt + CNT_W'(1);
               end
            ST_HEADER:
               if (skid_in_ready) begin
                  beat_cnt <= '0;
`ifdef CSI_CAPTURE_TIMESTAMP_EN
                  state    <= ST_TSTAMP;
`else
                  state    <= ST_PAYLOAD;
`endif
               end
`ifdef CSI_CAPTURE_TIMESTAMP_EN
            ST_TSTAMP:
               if (skid_in_ready)
                  state <= ST_PAYLOAD;
`endif
            ST_PAYLOAD:
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + BEAT_W'(1);
                  if (csi_s_axis_tlast || last_beat)
                     frame_count_out <= frame_count_out + 16'd1;
                  if (last_beat) begin
                     if (csi_s_axis_tlast) begin
                        state <= ST_HOLDOFF;
                     end else begin
                        state           <= ST_DRAIN;
                        error_count_out <= sat_inc16(error_count_out);
                     end
                  end else if (csi_s_axis_tlast) begin
                     state           <= ST_HOLDOFF;
                     error_count_out <= sat_inc16(error_count_out);
                  end
               end
            ST_DRAIN:
               if (csi_s_axis_tvalid && csi_s_axis_tlast)
                  state <= ST_HOLDOFF;
            ST_HOLDOFF:
               if (hold_cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                  state    <= ST_WAIT_POWER;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   csi_axis_skid #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_out_skid (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .in_valid  (skid_in_valid),
      .in_data   (skid_in_data),
      .in_last   (skid_in_last),
      .in_ready  (skid_in_ready),
      .out_valid (csi_m_axis_tvalid),
      .out_data  (csi_m_axis_tdata),
      .out_last  (csi_m_axis_tlast),
      .out_ready (csi_m_axis_tready)
   );

endmodule
